vram_plot: RTL and testbench

- Write-side companion to the VGA scanout engine: converts pixel-level drawing commands from the CPU or a script engine into read-modify-write accesses on the 8K video RAM.
- Uses the layout the scanout reads:
  - 256x192 linear bitmap at 0x0000.
  - 32x24 attribute array at 0x1800.
- Sits between the command source and the VRAM write port, which it shares with other masters via a hold input.

---
 rtl/vram_plot.sv | 143 ++++++++++++++
 tb/tb_vram_plot.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_plot.sv
// Pixel/attribute plotter: turns drawing commands into read-modify-write accesses on the 8K VRAM.
// Define VRAM_PLOT_CLS_EN to enable the clear-screen command (op 4).
module vram_plot #(
    parameter logic [12:0] ATTR_BASE = 13'h1800,
    parameter int          ROWS      = 192
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  cmd_x,
    input  logic [7:0]  cmd_y,
    input  logic [7:0]  cmd_attr,
    output logic        cmd_done,
    output logic [12:0] mem_a,
    input  logic [7:0]  mem_i,
    output logic [7:0]  mem_o,
    output logic        mem_we,
    input  logic        mem_hold
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LAT,
        S_WR,
        S_CLS
    } state_t;

    localparam logic [8:0]  ROWS_L    = ROWS[8:0];
    localparam logic [12:0] ATTR_LAST = ATTR_BASE + 13'd767;

    state_t      r_state;
    logic [1:0]  r_op;
    logic [2:0]  r_xbit;
    logic [12:0] r_addr;
    logic [7:0]  r_data;

    logic [12:0] w_bmp_addr;
    logic [12:0] w_attr_addr;
    logic        w_y_ok;
    logic [7:0]  w_mask;
    logic        w_write;

    assign w_bmp_addr  = {cmd_y, cmd_x[7:3]};
    assign w_attr_addr = ATTR_BASE | {3'b000, cmd_y[7:3], cmd_x[7:3]};
    assign w_y_ok      = ({1'b0, cmd_y} < ROWS_L);
    // MSB of a bitmap byte is the leftmost pixel
    assign w_mask      = 8'h80 >> r_xbit;

`ifdef VRAM_PLOT_CLS_EN
    logic [7:0]  r_attr;
    logic [12:0] w_addr_nxt;
    assign w_addr_nxt = r_addr + 13'd1;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= 2'd0;
            r_xbit  <= 3'd0;
            r_addr  <= 13'd0;
            r_data  <= 8'd0;
`ifdef VRAM_PLOT_CLS_EN
            r_attr  <= 8'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op   <= cmd_op[1:0];
                        r_xbit <= cmd_x[2:0];
`ifdef VRAM_PLOT_CLS_EN
                        r_attr <= cmd_attr;
`endif
                        case (cmd_op)
                            3'd0, 3'd1, 3'd2: begin
                                if (w_y_ok) begin
                                    r_addr  <= w_bmp_addr;
                                    r_state <= S_RD;
                                end
                            end
                            3'd3: begin
                                if (w_y_ok) begin
                                    r_addr  <= w_attr_addr;
                                    r_data  <= cmd_attr;
                                    r_state <= S_WR;
                                end
                            end
`ifdef VRAM_PLOT_CLS_EN
                            3'd4: begin
                                r_addr  <= 13'd0;
                                r_data  <= 8'd0;
                                r_state <= S_CLS;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                S_RD: begin
                    if (!mem_hold)
                        r_state <= S_LAT;
                end
                S_LAT: begin
                    // read already issued, so hold does not matter here
                    case (r_op)
                        2'd0:    r_data <= mem_i | w_mask;
                        2'd1:    r_data <= mem_i & ~w_mask;
                        default: r_data <= mem_i ^ w_mask;
                    endcase
                    r_state <= S_WR;
                end
                S_WR: begin
                    if (!mem_hold)
                        r_state <= S_IDLE;
                end
`ifdef VRAM_PLOT_CLS_EN
                S_CLS: begin
                    if (!mem_hold) begin
                        if (r_addr == ATTR_LAST) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_addr <= w_addr_nxt;
                            r_data <= (w_addr_nxt >= ATTR_BASE) ? r_attr : 8'd0;
                        end
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_write   = ((r_state == S_WR) || (r_state == S_CLS)) && !mem_hold && !reset;
    assign mem_we    = w_write;
    assign cmd_done  = w_write && ((r_state == S_WR) || (r_addr == ATTR_LAST));
    assign cmd_ready = (r_state == S_IDLE) && !reset;
    assign mem_a     = r_addr;
    assign mem_o     = r_data;

endmodule

// File: tb/tb_vram_plot.sv
// Directed bench for vram_plot: command vector table plus reset, abort and clear-screen sequences.
// Clear-screen sequence is compiled only with VRAM_PLOT_CLS_EN.
module tb_vram_plot;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_x;
    logic [7:0]  cmd_y;
    logic [7:0]  cmd_attr;
    logic        cmd_done;
    logic [12:0] mem_a;
    logic [7:0]  mem_i;
    logic [7:0]  mem_o;
    logic        mem_we;
    logic        mem_hold;

    logic        pl_en;
    logic [12:0] pl_addr;
    logic [7:0]  pl_data;
    logic [7:0]  vram [0:8191];

    int n_vec  = 0;
    int n_miss = 0;

    int obs_wr_cnt, obs_wr_addr, obs_wr_data, obs_done_cnt, obs_done_cyc;
    int obs_ready_cyc, obs_hold_viol, obs_rd_addr, obs_rd_we;

    vram_plot dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_attr(cmd_attr), .cmd_done(cmd_done),
        .mem_a(mem_a), .mem_i(mem_i), .mem_o(mem_o), .mem_we(mem_we), .mem_hold(mem_hold)
    );

    always #5 clock = ~clock;

    // VRAM model: synchronous read, write on mem_we, bench preload port
    always @(posedge clock) begin
        if (pl_en)
            vram[pl_addr] <= pl_data;
        else if (mem_we)
            vram[mem_a] <= mem_o;
        mem_i <= vram[mem_a];
    end

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [7:0]  attr;
        logic [31:0] hmask;
        bit          pre;
        logic [12:0] addr;
        logic [7:0]  init;
        int          n_wr;
        logic [7:0]  wdata;
        int          done_cyc;
        int          ready_cyc;
        bit          rd;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input int act, input int exp);
        if (act != exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
            n_miss++;
        end
    endtask

    task automatic preload(input logic [12:0] a, input logic [7:0] d);
        @(negedge clock);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clock);
        pl_en = 1'b0;
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] attr, input logic [31:0] hmask);
        @(negedge clock);
        mem_hold = 1'b0;
        cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y; cmd_attr = attr;
        #1;
        check("ready_at_issue", int'(cmd_ready), 1);
        @(negedge clock);
        // scramble command inputs to prove they were latched
        cmd_valid = 1'b0; cmd_op = 3'd7; cmd_x = ~x; cmd_y = ~y; cmd_attr = ~attr;
        obs_wr_cnt = 0; obs_wr_addr = -1; obs_wr_data = -1; obs_done_cnt = 0;
        obs_done_cyc = -1; obs_ready_cyc = -1; obs_hold_viol = 0; obs_rd_addr = -1; obs_rd_we = -1;
        for (int k = 1; k <= 20; k++) begin
            mem_hold = (k < 32) ? hmask[k] : 1'b0;
            #1;
            if (k == 1) begin
                obs_rd_addr = int'(mem_a);
                obs_rd_we   = int'(mem_we);
            end
            if (mem_we) begin
                obs_wr_cnt++;
                obs_wr_addr = int'(mem_a);
                obs_wr_data = int'(mem_o);
            end
            if (mem_we && mem_hold) obs_hold_viol++;
            if (cmd_done) begin
                obs_done_cnt++;
                obs_done_cyc = k;
            end
            if (cmd_ready && obs_ready_cyc < 0) obs_ready_cyc = k;
            @(negedge clock);
        end
        mem_hold = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_x = 8'd0; cmd_y = 8'd0;
        cmd_attr = 8'd0; mem_hold = 1'b0; pl_en = 1'b0; pl_addr = 13'd0; pl_data = 8'd0;

        //            op    x       y       attr    hmask   pre addr      init   nwr wdata  done rdy rd
        vt.push_back('{3'd0, 8'd10,  8'd5,   8'h00, 32'h0,  1, 13'h00A1, 8'h00, 1, 8'h20, 3, 4, 1});
        vt.push_back('{3'd1, 8'd7,   8'd0,   8'h00, 32'h0,  1, 13'h0000, 8'hFF, 1, 8'hFE, 3, 4, 1});
        vt.push_back('{3'd2, 8'd0,   8'd0,   8'h00, 32'h0,  0, 13'h0000, 8'h00, 1, 8'h7E, 3, 4, 1});
        vt.push_back('{3'd3, 8'd255, 8'd191, 8'h38, 32'h0,  0, 13'h1AFF, 8'h00, 1, 8'h38, 1, 2, 0});
        vt.push_back('{3'd0, 8'd3,   8'd100, 8'h00, 32'hCE, 1, 13'h0C80, 8'h81, 1, 8'h91, 8, 9, 1});
        vt.push_back('{3'd0, 8'd10,  8'd200, 8'h00, 32'h0,  0, 13'h0000, 8'h00, 0, 8'h00, -1, 1, 0});
        vt.push_back('{3'd5, 8'd1,   8'd0,   8'h00, 32'h0,  0, 13'h0000, 8'h00, 0, 8'h00, -1, 1, 0});
`ifndef VRAM_PLOT_CLS_EN
        vt.push_back('{3'd4, 8'd0,   8'd0,   8'h07, 32'h0,  0, 13'h0000, 8'h00, 0, 8'h00, -1, 1, 0});
`endif
        vt.push_back('{3'd2, 8'd255, 8'd191, 8'h00, 32'h0,  1, 13'h17FF, 8'h01, 1, 8'h00, 3, 4, 1});
        vt.push_back('{3'd0, 8'd8,   8'd1,   8'h00, 32'h0,  1, 13'h0021, 8'h80, 1, 8'h80, 3, 4, 1});
        vt.push_back('{3'd1, 8'd15,  8'd2,   8'h00, 32'h0,  1, 13'h0041, 8'h00, 1, 8'h00, 3, 4, 1});
        vt.push_back('{3'd3, 8'd0,   8'd192, 8'h55, 32'h0,  0, 13'h0000, 8'h00, 0, 8'h00, -1, 1, 0});
        vt.push_back('{3'd2, 8'd1,   8'd3,   8'h00, 32'h08, 1, 13'h0060, 8'h40, 1, 8'h00, 4, 5, 1});

        // reset state
        repeat (3) @(negedge clock);
        #1;
        n_vec++;
        check("rst_ready", int'(cmd_ready), 0);
        check("rst_we", int'(mem_we), 0);
        check("rst_done", int'(cmd_done), 0);
        check("rst_mem_a", int'(mem_a), 0);
        check("rst_mem_o", int'(mem_o), 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("post_rst_ready", int'(cmd_ready), 1);
        check("post_rst_mem_a", int'(mem_a), 0);
        check("post_rst_we", int'(mem_we), 0);

        foreach (vt[i]) begin
            n_vec++;
            if (vt[i].pre) preload(vt[i].addr, vt[i].init);
            run_cmd(vt[i].op, vt[i].x, vt[i].y, vt[i].attr, vt[i].hmask);
            check($sformatf("v%0d_wr_cnt", i), obs_wr_cnt, vt[i].n_wr);
            check($sformatf("v%0d_done_cnt", i), obs_done_cnt, (vt[i].n_wr > 0) ? 1 : 0);
            check($sformatf("v%0d_done_cyc", i), obs_done_cyc, vt[i].done_cyc);
            check($sformatf("v%0d_ready_cyc", i), obs_ready_cyc, vt[i].ready_cyc);
            check($sformatf("v%0d_hold_viol", i), obs_hold_viol, 0);
            if (vt[i].n_wr > 0) begin
                check($sformatf("v%0d_wr_addr", i), obs_wr_addr, int'(vt[i].addr));
                check($sformatf("v%0d_wr_data", i), obs_wr_data, int'(vt[i].wdata));
            end
            if (vt[i].rd) begin
                check($sformatf("v%0d_rd_addr", i), obs_rd_addr, int'(vt[i].addr));
                check($sformatf("v%0d_rd_we", i), obs_rd_we, 0);
            end
        end

        // reset while in LAT aborts the command
        n_vec++;
        preload(13'h00A1, 8'h00);
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_x = 8'd10; cmd_y = 8'd5;
        @(negedge clock);
        cmd_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("abort_we_in_rst", int'(mem_we), 0);
        check("abort_done_in_rst", int'(cmd_done), 0);
        check("abort_ready_in_rst", int'(cmd_ready), 0);
        @(negedge clock);
        reset = 1'b0;
        obs_wr_cnt = 0; obs_done_cnt = 0;
        #1;
        check("abort_ready_after", int'(cmd_ready), 1);
        check("abort_mem_a_after", int'(mem_a), 0);
        for (int k = 0; k < 10; k++) begin
            #1;
            if (mem_we) obs_wr_cnt++;
            if (cmd_done) obs_done_cnt++;
            @(negedge clock);
        end
        check("abort_wr_cnt", obs_wr_cnt, 0);
        check("abort_done_cnt", obs_done_cnt, 0);
        check("abort_vram_kept", int'(vram[13'h00A1]), 0);

`ifdef VRAM_PLOT_CLS_EN
        begin
            int nwr, bad_addr, bad_data, ndone, viol, done_at;
            bit fin;
            nwr = 0; bad_addr = 0; bad_data = 0; ndone = 0; viol = 0; done_at = -1; fin = 0;
            n_vec++;
            @(negedge clock);
            cmd_valid = 1'b1; cmd_op = 3'd4; cmd_x = 8'd0; cmd_y = 8'd200; cmd_attr = 8'h07;
            @(negedge clock);
            cmd_valid = 1'b0; cmd_attr = 8'hAA;
            for (int k = 1; k <= 8000 && !fin; k++) begin
                mem_hold = (k % 97 == 0);
                #1;
                if (mem_we && mem_hold) viol++;
                if (mem_we) begin
                    if (int'(mem_a) != nwr) bad_addr++;
                    if (int'(mem_o) != ((nwr < 6144) ? 0 : 7)) bad_data++;
                    nwr++;
                end
                if (cmd_done) begin
                    ndone++;
                    done_at = nwr;
                end
                if (cmd_ready) fin = 1;
                @(negedge clock);
            end
            mem_hold = 1'b0;
            check("cls_finished", int'(fin), 1);
            check("cls_wr_cnt", nwr, 6912);
            check("cls_bad_addr", bad_addr, 0);
            check("cls_bad_data", bad_data, 0);
            check("cls_done_cnt", ndone, 1);
            check("cls_done_at_last", done_at, 6912);
            check("cls_hold_viol", viol, 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
